// File: rtl/video_timing_pkg.sv
// Shared raster timing constants, position type and window helper for the
// video sync generator and the downstream playfield pixel stages.
package video_timing_pkg;

    localparam int CNT_W = 9;

    localparam int H_TOTAL_DEF      = 384;
    localparam int H_ACTIVE_DEF     = 256;
    localparam int H_SYNC_START_DEF = 296;
    localparam int H_SYNC_WIDTH_DEF = 32;

    localparam int V_TOTAL_DEF      = 264;
    localparam int V_ACTIVE_DEF     = 240;
    localparam int V_SYNC_START_DEF = 248;
    localparam int V_SYNC_WIDTH_DEF = 3;

    typedef struct packed {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] v;
    } video_pos_t;

    // Half-open window test done in int so start+width may equal 2**CNT_W.
    function automatic logic in_window(input int pos, input int start, input int width);
        return (pos >= start) && (pos < start + width);
    endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Modulo-N counter with enable; exposes the registered count, the value it
// will take on the next edge, and a terminal-count flag (count == N-1).
module video_sync_counter
    import video_timing_pkg::*;
#(
    parameter int N = 384,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         tc
);

    logic [W-1:0] count_reg;

    assign count = count_reg;
    assign tc    = (count_reg == W'(N - 1));

    always_comb begin
        count_next = count_reg;
        if (en) begin
            count_next = tc ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/video_sync_timing.sv
// Raster timing generator: H/V counters, active-low syncs, blanking and strobes.
// Define VIDEO_SYNC_TIMING_IRQ_EN to build the frame interrupt latch on IRQ_AL.
module video_sync_timing
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL      = H_TOTAL_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_SYNC_START = H_SYNC_START_DEF,
    parameter int H_SYNC_WIDTH = H_SYNC_WIDTH_DEF,
    parameter int V_TOTAL      = V_TOTAL_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_SYNC_START = V_SYNC_START_DEF,
    parameter int V_SYNC_WIDTH = V_SYNC_WIDTH_DEF,
    parameter int CNT_W        = video_timing_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PIX_CE,
    input  logic             IRQ_ACK,
    output logic [CNT_W-1:0] H_CNT,
    output logic [CNT_W-1:0] V_CNT,
    output logic             TRGA_AL,
    output logic             VSYNC_AL,
    output logic             HBLANK,
    output logic             VBLANK,
    output logic             BLANK_AL,
    output logic             LINE_START,
    output logic             FRAME_START,
    output logic             IRQ_AL
);

    if (H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_chk_hsync
        $fatal(1, "video_sync_timing: H sync window extends past H_TOTAL");
    end
    if (V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_chk_vsync
        $fatal(1, "video_sync_timing: V sync window extends past V_TOTAL");
    end
    if (H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL) begin : g_chk_active
        $fatal(1, "video_sync_timing: active region must be smaller than total");
    end
    if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_chk_width
        $fatal(1, "video_sync_timing: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_tc;
    logic             v_en;
    logic             v_tc_unused;

    // V advances only on the enabled edge where H wraps.
    assign v_en = PIX_CE & h_tc;

    video_sync_counter #(
        .N (H_TOTAL),
        .W (CNT_W)
    ) u_h_counter (
        .clk        (CLK),
        .rst        (RST),
        .en         (PIX_CE),
        .count      (H_CNT),
        .count_next (h_next),
        .tc         (h_tc)
    );

    video_sync_counter #(
        .N (V_TOTAL),
        .W (CNT_W)
    ) u_v_counter (
        .clk        (CLK),
        .rst        (RST),
        .en         (v_en),
        .count      (V_CNT),
        .count_next (v_next),
        .tc         (v_tc_unused)
    );

    logic h_blank_next;
    logic v_blank_next;
    logic h_sync_next;
    logic v_sync_next;
    logic h_zero_next;
    logic v_zero_next;

    always_comb begin
        h_blank_next = int'(h_next) >= H_ACTIVE;
        v_blank_next = int'(v_next) >= V_ACTIVE;
        h_sync_next  = in_window(int'(h_next), H_SYNC_START, H_SYNC_WIDTH);
        v_sync_next  = in_window(int'(v_next), V_SYNC_START, V_SYNC_WIDTH);
        h_zero_next  = (h_next == '0);
        v_zero_next  = (v_next == '0);
    end

    // Decoding the next counts keeps every flag aligned with H_CNT/V_CNT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TRGA_AL     <= 1'b1;
            VSYNC_AL    <= 1'b1;
            HBLANK      <= 1'b0;
            VBLANK      <= 1'b0;
            BLANK_AL    <= 1'b1;
            LINE_START  <= 1'b1;
            FRAME_START <= 1'b1;
        end else begin
            TRGA_AL     <= ~h_sync_next;
            VSYNC_AL    <= ~v_sync_next;
            HBLANK      <= h_blank_next;
            VBLANK      <= v_blank_next;
            BLANK_AL    <= ~(h_blank_next | v_blank_next);
            LINE_START  <= h_zero_next;
            FRAME_START <= h_zero_next & v_zero_next;
        end
    end

`ifdef VIDEO_SYNC_TIMING_IRQ_EN
    logic irq_set;

    assign irq_set = v_en && (int'(v_next) == V_ACTIVE);

    // Set has priority over a coincident acknowledge; ack ignores PIX_CE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            IRQ_AL <= 1'b1;
        end else if (irq_set) begin
            IRQ_AL <= 1'b0;
        end else if (IRQ_ACK) begin
            IRQ_AL <= 1'b1;
        end
    end
`else
    logic irq_ack_unused;

    assign irq_ack_unused = IRQ_ACK;
    assign IRQ_AL         = 1'b1;
`endif

endmodule
